// File: rtl/imem_loader_pkg.sv
// Constants and state encoding shared by the loader, the program counter and the instruction RAM.
package imem_loader_pkg;

   localparam int         DEPTH     = 16;
   localparam int         ADDR_W    = 4;
   localparam int         INSTR_W   = 8;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         TIMEOUT   = 255;
   localparam int         TO_W      = 8;

   typedef enum logic [2:0] {
      WAIT_SYNC,
      GET_COUNT,
      GET_DATA,
      GET_CSUM,
      RUN,
      ERROR
   } state_t;

endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte idle counter: expires after TIMEOUT consecutive enabled cycles without a clear.
module imem_loader_timeout
   import imem_loader_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic enable_i,
   input  logic clear_i,
   output logic expired_o
);

   logic [TO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || !enable_i) begin
         cnt_d = '0;
      end else if (cnt_q != TO_W'(TIMEOUT - 1)) begin
         cnt_d = cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires on the TIMEOUT-th idle cycle so the abort edge lands exactly TIMEOUT cycles after the last byte.
   assign expired_o = enable_i && !clear_i && (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/imem_loader.sv
// Frame receiver that writes a checksummed program into the instruction RAM and holds the core until it is valid.
module imem_loader
   import imem_loader_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               cpu_reset_hold,
   output logic               load_done,
   output logic               load_error
);

   state_t               state_q, state_d;
   logic [7:0]           count_q, count_d;
   logic [7:0]           idx_q, idx_d;
   logic [7:0]           csum_q, csum_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [INSTR_W-1:0]   wdata_q, wdata_d;
   logic                 hold_q, hold_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 rdy_q;
   logic                 hs, is_sync, to_en, to_expired;

   assign hs      = in_valid && rdy_q;
   assign is_sync = (in_data == SYNC_BYTE);
   assign to_en   = (state_q == GET_COUNT) || (state_q == GET_DATA) || (state_q == GET_CSUM);

   imem_loader_timeout u_timeout (
      .clk       (clk),
      .reset     (reset),
      .enable_i  (to_en),
      .clear_i   (hs),
      .expired_o (to_expired)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;
      csum_d  = csum_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         WAIT_SYNC, RUN, ERROR: begin
            if (hs && is_sync) state_d = GET_COUNT;
         end
         GET_COUNT: begin
            if (hs) begin
               if (in_data != 8'd0 && in_data <= 8'(DEPTH)) begin
                  count_d = in_data;
                  idx_d   = 8'd0;
                  csum_d  = 8'd0;
                  state_d = GET_DATA;
               end else begin
                  state_d = ERROR;
               end
            end else if (to_expired) begin
               state_d = ERROR;
            end
         end
         GET_DATA: begin
            if (hs) begin
               we_d    = 1'b1;
               addr_d  = idx_q[ADDR_W-1:0];
               wdata_d = in_data;
               csum_d  = csum_q ^ in_data;
               idx_d   = idx_q + 8'd1;
               if (idx_q == count_q - 8'd1) state_d = GET_CSUM;
            end else if (to_expired) begin
               state_d = ERROR;
            end
         end
         GET_CSUM: begin
            if (hs) begin
               state_d = (in_data == csum_q) ? RUN : ERROR;
            end else if (to_expired) begin
               state_d = ERROR;
            end
         end
         default: state_d = WAIT_SYNC;
      endcase
      // Status flags follow the next state so they change on the same edge as the transition.
      hold_d = (state_d != RUN);
      done_d = (state_d == RUN);
      err_d  = (state_d == ERROR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= WAIT_SYNC;
         count_q <= '0;
         idx_q   <= '0;
         csum_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         csum_q  <= csum_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdy_q   <= 1'b1;
      end
   end

   assign in_ready       = rdy_q;
   assign imem_we        = we_q;
   assign imem_addr      = addr_q;
   assign imem_wdata     = wdata_q;
   assign cpu_reset_hold = hold_q;
   assign load_done      = done_q;
   assign load_error     = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed checks of imem_loader against a frame-level reference model.
module tb_imem_loader;
   import imem_loader_pkg::*;

   typedef logic [7:0] bq_t[$];

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               in_valid = 1'b0;
   logic [7:0]         in_data = 8'h00;
   logic               in_ready;
   logic               imem_we;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_wdata;
   logic               cpu_reset_hold;
   logic               load_done;
   logic               load_error;

   int n_tests = 0;
   int n_fail  = 0;
   logic [ADDR_W+INSTR_W-1:0] wr_q[$];

   imem_loader dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .imem_we        (imem_we),
      .imem_addr      (imem_addr),
      .imem_wdata     (imem_wdata),
      .cpu_reset_hold (cpu_reset_hold),
      .load_done      (load_done),
      .load_error     (load_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && imem_we) wr_q.push_back({imem_addr, imem_wdata});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1 time unit after the handshake edge, where registered results are visible.
   task automatic send(input logic [7:0] b, input int gap);
      if (gap > 0) idle(gap);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic make_frame(input int cnt, input bit bad, output bq_t f);
      logic [7:0] x, b;
      f = {};
      f.push_back(SYNC_BYTE);
      f.push_back(8'(cnt));
      if (cnt >= 1 && cnt <= DEPTH) begin
         x = 8'h00;
         for (int i = 0; i < cnt; i++) begin
            b = 8'($urandom);
            f.push_back(b);
            x ^= b;
         end
         if (bad) x ^= 8'(($urandom_range(1, 255)));
         f.push_back(x);
      end
   endtask

   // Reference: legal count writes bytes to addr 0..count-1; RUN iff the trailer equals their XOR.
   task automatic frame(input string tag, input bq_t f, input int maxgap);
      logic [ADDR_W+INSTR_W-1:0] exp_q[$];
      logic [7:0] x;
      int cnt;
      bit good;
      wr_q.delete();
      foreach (f[i]) send(f[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      idle(2);
      cnt  = int'(f[1]);
      good = 1'b0;
      if (cnt >= 1 && cnt <= DEPTH) begin
         x = 8'h00;
         for (int i = 0; i < cnt; i++) begin
            exp_q.push_back({ADDR_W'(i), f[2+i]});
            x ^= f[2+i];
         end
         good = (f[cnt+2] == x);
      end
      chk($sformatf("%s_nwr", tag), wr_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
         if (i < wr_q.size()) chk($sformatf("%s_wr%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
      end
      chk($sformatf("%s_done", tag), load_done, good);
      chk($sformatf("%s_err", tag), load_error, !good);
      chk($sformatf("%s_hold", tag), cpu_reset_hold, !good);
   endtask

   initial begin
      bq_t f;
      logic [7:0] b;
      int cnt, r;

      // Reset values
      #1 reset = 1'b1;
      idle(3);
      chk("rst_rdy", in_ready, 1'b0);
      chk("rst_we", imem_we, 1'b0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_wdata", 32'(imem_wdata), 32'd0);
      chk("rst_hold", cpu_reset_hold, 1'b1);
      chk("rst_done", load_done, 1'b0);
      chk("rst_err", load_error, 1'b0);
      chk("rst_state", 32'(dut.state_q), 32'(WAIT_SYNC));
      reset = 1'b0;
      idle(1);
      chk("rdy_after_rst", in_ready, 1'b1);

      // Good frame with strobe timing
      wr_q.delete();
      send(8'hA5, 0);
      send(8'h03, 1);
      send(8'h11, 0);
      chk("good_we_next", imem_we, 1'b1);
      chk("good_addr0", 32'(imem_addr), 32'h0);
      chk("good_wdata0", 32'(imem_wdata), 32'h11);
      idle(1);
      chk("good_we_one", imem_we, 1'b0);
      send(8'h22, 0);
      send(8'h44, 2);
      send(8'h77, 0);
      chk("good_hold_next", cpu_reset_hold, 1'b0);
      chk("good_done_next", load_done, 1'b1);
      chk("good_err", load_error, 1'b0);
      idle(1);
      chk("good_nwr", wr_q.size(), 3);
      if (wr_q.size() == 3) begin
         chk("good_w1", 32'(wr_q[1]), 32'h122);
         chk("good_w2", 32'(wr_q[2]), 32'h244);
      end

      // Bad checksum, then recovery
      f = '{8'hA5, 8'h02, 8'h0F, 8'hF0, 8'h00};
      frame("badcs", f, 1);
      send(8'hA5, 0);
      chk("recov_err_clr", load_error, 1'b0);
      f = '{8'h01, 8'h3C, 8'h3C};
      foreach (f[i]) send(f[i], 0);
      chk("recov_done", load_done, 1'b1);
      chk("recov_hold", cpu_reset_hold, 1'b0);

      // Illegal counts
      f = '{8'hA5, 8'h00};
      frame("cnt0", f, 0);
      f = '{8'hA5, 8'h11};
      frame("cnt17", f, 0);

      // Timeout inside a frame
      send(8'hA5, 0);
      send(8'h02, 0);
      send(8'h12, 0);
      idle(TIMEOUT - 3);
      chk("to_early", load_error, 1'b0);
      idle(5);
      chk("to_err", load_error, 1'b1);
      chk("to_hold", cpu_reset_hold, 1'b1);
      wr_q.delete();
      f = '{8'h01, 8'h3C, 8'h3C};
      foreach (f[i]) send(f[i], 0);
      idle(2);
      chk("to_drop_nwr", wr_q.size(), 0);
      chk("to_drop_err", load_error, 1'b1);

      // Reload from RUN
      make_frame(5, 1'b0, f);
      frame("preload", f, 2);
      wr_q.delete();
      send(8'hA5, 0);
      chk("reload_hold", cpu_reset_hold, 1'b1);
      chk("reload_done", load_done, 1'b0);
      f = '{8'h02, 8'h5A, 8'hC3, 8'h99};
      foreach (f[i]) send(f[i], 0);
      idle(2);
      chk("reload_nwr", wr_q.size(), 2);
      if (wr_q.size() == 2) begin
         chk("reload_w0", 32'(wr_q[0]), 32'h05A);
         chk("reload_w1", 32'(wr_q[1]), 32'h1C3);
      end
      chk("reload_run", load_done, 1'b1);

      // Randomized frames, with dropped junk between them
      for (int k = 0; k < 25; k++) begin
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            do b = 8'($urandom); while (b == SYNC_BYTE);
            send(b, 0);
         end
         r = int'($urandom_range(0, 9));
         if (r == 0) cnt = 0;
         else if (r == 1) cnt = int'($urandom_range(DEPTH + 1, 255));
         else cnt = int'($urandom_range(1, DEPTH));
         make_frame(cnt, ($urandom_range(0, 3) == 0), f);
         frame($sformatf("rnd%0d", k), f, 3);
      end

      // Async reset with a write strobe pending
      send(8'hA5, 0);
      send(8'h04, 0);
      send(8'hAA, 0);
      send(8'hBB, 0);
      chk("mid_we_pending", imem_we, 1'b1);
      reset = 1'b1;
      #1;
      chk("mid_we", imem_we, 1'b0);
      chk("mid_hold", cpu_reset_hold, 1'b1);
      chk("mid_done", load_done, 1'b0);
      chk("mid_state", 32'(dut.state_q), 32'(WAIT_SYNC));
      idle(2);
      reset = 1'b0;
      idle(1);
      make_frame(3, 1'b0, f);
      frame("post_rst", f, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a framed program over a byte valid/ready stream and writes it into the loadable instruction RAM that the program counter reads.
- Holds the CPU core in reset while a load is in progress.
- Releases the core only after a frame is received completely and its checksum matches.
- Sits between the host/debug byte link and the core top, which is the reader of the same memory.

Parameters:
DEPTH, 16, number of instruction words; valid count range is 1..DEPTH
ADDR_W, 4, instruction address width; DEPTH <= 2**ADDR_W
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT, 255, maximum idle cycles between bytes inside a frame before abort

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  byte available on in_data
in_data  in  8  stream byte
in_ready  out  1  loader can accept a byte; a byte transfers when in_valid && in_ready at a rising edge of clk
imem_we  out  1  single-cycle write strobe to the instruction RAM
imem_addr  out  ADDR_W  write address
imem_wdata  out  8  instruction word
cpu_reset_hold  out  1  OR'd into the core reset; 1 = core held in reset
load_done  out  1  high while a valid program is loaded and the core is running
load_error  out  1  sticky error flag; cleared by the next sync byte

Behaviour:
- Frame format: SYNC_BYTE, COUNT (1..DEPTH), COUNT instruction bytes, CSUM. CSUM is the XOR of all instruction bytes, seed 8'h00.
- Reset values: state=WAIT_SYNC, in_ready=0 during reset, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset_hold=1, load_done=0, load_error=0. in_ready goes to 1 on the first cycle after reset deasserts.
- States:
  - WAIT_SYNC. A SYNC_BYTE goes to GET_COUNT. Other bytes are consumed and dropped.
  - GET_COUNT. COUNT in 1..DEPTH: latch it, clear the address counter and checksum, go to GET_DATA. COUNT = 0 or > DEPTH: go to ERROR.
  - GET_DATA. On each accepted byte, register imem_we=1, imem_addr=counter, imem_wdata=byte. The strobe appears exactly 1 cycle after the handshake, for 1 cycle. The counter increments and the checksum is XORed with the byte. After the COUNT-th byte, go to GET_CSUM.
  - GET_CSUM. Byte equal to the running checksum: go to RUN. Otherwise go to ERROR.
  - RUN. cpu_reset_hold=0 and load_done=1, both starting the cycle after the CSUM handshake. A SYNC_BYTE causes a reload: go to GET_COUNT, with cpu_reset_hold=1 and load_done=0 starting the next cycle. Other bytes are dropped.
  - ERROR. load_error=1, cpu_reset_hold=1, load_done=0. A SYNC_BYTE clears load_error and goes to GET_COUNT. Other bytes are dropped.
- in_ready is 1 in every state; the loader never back-pressures.
- Timeout: a cycle counter runs in GET_COUNT/GET_DATA/GET_CSUM and resets on every handshake. When it reaches TIMEOUT, go to ERROR. Partially written words stay in the RAM; they are harmless because the core stays held.
- cpu_reset_hold is 1 in every state except RUN.
- A SYNC_BYTE value inside GET_COUNT/GET_DATA/GET_CSUM is treated as data, not as a restart.
- RAM locations at or above COUNT are not written or cleared.
- Async reset in mid-frame returns to WAIT_SYNC immediately and aborts any pending write strobe. RAM contents are unspecified, and the core stays held.
- All outputs are registered; there are no combinational paths from in_* to imem_* or cpu_reset_hold.

Decomposition:
- Shared CPU package: the state enumeration (WAIT_SYNC, GET_COUNT, GET_DATA, GET_CSUM, RUN, ERROR), SYNC_BYTE, and the instruction and address widths shared with the program counter and the instruction memory.
- One natural sub-module: imem_loader_timeout. It is the inter-byte idle counter, with inputs enable and clear and a single expired output.

Test Plan:
- Good frame: send A5,03,11,22,44,77. Required: imem_we pulses writing addr0=11, addr1=22, addr2=44. cpu_reset_hold falls and load_done rises 1 cycle after the 77 handshake. load_error stays 0.
- Bad checksum: send A5,02,0F,F0,00. Required: 2 writes, then load_error=1, cpu_reset_hold=1, load_done=0. Then send A5,01,3C,3C. Required: load_error clears on the A5 and RUN is reached.
- Illegal count: send A5,00 and, separately, A5,11 (17 > DEPTH). Required: ERROR with no imem_we pulses.
- Timeout: send A5,02,12, then idle TIMEOUT cycles. Required: ERROR with cpu_reset_hold=1. Bytes received afterwards are dropped until the next A5.
- Reload from RUN: after a good load, send A5. Required: cpu_reset_hold=1 and load_done=0 the next cycle. A full new frame overwrites the RAM from addr 0.
- Reset mid-frame: assert reset during GET_DATA, with a write strobe pending. Required: imem_we=0, cpu_reset_hold=1 and state WAIT_SYNC immediately, with no clock edge needed. A5 handling works normally after reset is released.
